// File: rtl/serial_ripple_subtractor_pkg.sv
// +------------------------------------------------------------------+
// | serial_ripple_subtractor_pkg: shared FSM encoding and defaults   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package serial_ripple_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_ripple_subtractor_cell.sv
// +------------------------------------------------------------------+
// | one_bit_full_subtractor: combinational single-bit subtract cell  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module one_bit_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

`default_nettype wire

// File: rtl/serial_ripple_subtractor.sv
// +------------------------------------------------------------------+
// | serial_ripple_subtractor: bit-serial A-B, LSB first, 1 bit/cycle |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module serial_ripple_subtractor
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int                 IDX_W    = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_result;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_borrow;
  logic [IDX_W-1:0] r_idx;

  logic             w_diff_bit;
  logic             w_borrow_nxt;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_result_nxt;

  one_bit_full_subtractor u_cell (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .b_in  (r_borrow),
    .diff  (w_diff_bit),
    .b_out (w_borrow_nxt)
  );

  assign w_accept     = (r_state == ST_IDLE) && start;
  assign w_last       = (r_state == ST_RUN) && (r_idx == LAST_IDX);
  assign w_result_nxt = {w_diff_bit, r_result[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Operands shift right so the cell always sees bit 0; MSBs are kept aside for overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_result   <= '0;
      r_borrow   <= 1'b0;
      r_idx      <= '0;
      difference <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh   <= minuend;
      r_b_sh   <= subtrahend;
      r_a_msb  <= minuend[WIDTH-1];
      r_b_msb  <= subtrahend[WIDTH-1];
      r_result <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_result <= w_result_nxt;
      r_borrow <= w_borrow_nxt;
      r_idx    <= r_idx + IDX_ONE;
      if (w_last) begin
        // The final bit is the result MSB, so publish straight from the cell outputs.
        difference <= w_result_nxt;
        borrow_out <= w_borrow_nxt;
        overflow   <= (r_a_msb != r_b_msb) && (w_diff_bit != r_a_msb);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_ripple_subtractor.sv
// +------------------------------------------------------------------+
// | tb_serial_ripple_subtractor: directed + random checks, WIDTH=8   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_serial_ripple_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
  logic             overflow;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  serial_ripple_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation; the edge sampling start counts as edge 1, so done shows after edge WIDTH+1.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit hold, input int mid_k, input string tag);
    logic [WIDTH-1:0] exp_diff;
    logic             exp_borrow;
    logic             exp_ovf;
    logic [WIDTH-1:0] prev_diff;
    logic             prev_borrow;
    logic             prev_ovf;
    int               done_at;
    int               busy_cnt;
    bit               moved;

    exp_diff   = a - b;
    exp_borrow = (a < b);
    exp_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (exp_diff[WIDTH-1] != a[WIDTH-1]);

    @(negedge clk);
    minuend    = a;
    subtrahend = b;
    start      = 1'b1;
    prev_diff   = difference;
    prev_borrow = borrow_out;
    prev_ovf    = overflow;
    done_at  = 0;
    busy_cnt = 0;
    moved    = 1'b0;

    for (int k = 1; k <= WIDTH + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        if (!hold) start = 1'b0;
        minuend    = WIDTH'($urandom);
        subtrahend = WIDTH'($urandom);
      end
      if (mid_k != 0 && k == mid_k) begin
        start      = 1'b1;
        minuend    = '1;
        subtrahend = '0;
      end
      if (mid_k != 0 && k == mid_k + 1) start = hold;
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = k;
      if (!done && (difference !== prev_diff || borrow_out !== prev_borrow || overflow !== prev_ovf))
        moved = 1'b1;
    end

    check_value({tag, "_latency"}, 64'(done_at), 64'(WIDTH + 1));
    check_value({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
    check_value({tag, "_outputs_stable_in_run"}, 64'(moved), 64'd0);
    check_value({tag, "_difference"}, 64'(difference), 64'(exp_diff));
    check_value({tag, "_borrow_out"}, 64'(borrow_out), 64'(exp_borrow));
    check_value({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));

    @(posedge clk);
    #1;
    check_value({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  task automatic watch_no_done(input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check_value(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    minuend    = '0;
    subtrahend = '0;
    repeat (2) @(posedge clk);
    #1;
    check_value("reset_busy", 64'(busy), 64'd0);
    check_value("reset_done", 64'(done), 64'd0);
    check_value("reset_difference", 64'(difference), 64'd0);
    check_value("reset_borrow_out", 64'(borrow_out), 64'd0);
    check_value("reset_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(8'h05, 8'h03, 1'b0, 0, "d_05_03");
    do_op(8'h03, 8'h05, 1'b0, 0, "d_03_05");
    do_op(8'h80, 8'h01, 1'b0, 0, "d_80_01");
    do_op(8'h7F, 8'hFF, 1'b0, 0, "d_7f_ff");

    // A start pulse in the middle of RUN must be dropped entirely.
    do_op(8'h10, 8'h01, 1'b0, 4, "mid_start");
    watch_no_done(12, "mid_start_no_second_done");

    @(negedge clk);
    minuend    = 8'h5A;
    subtrahend = 8'h21;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check_value("rst_async_busy", 64'(busy), 64'd0);
    check_value("rst_async_done", 64'(done), 64'd0);
    check_value("rst_async_difference", 64'(difference), 64'd0);
    check_value("rst_async_borrow_out", 64'(borrow_out), 64'd0);
    check_value("rst_async_overflow", 64'(overflow), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    watch_no_done(12, "rst_abort_no_done");
    do_op(8'h00, 8'h00, 1'b0, 0, "post_rst_00_00");

    for (int i = 0; i < 1000; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), bit'($urandom_range(0, 1)), 0, "rand");
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

`default_nettype wire
